// File: rtl/serial_paralelo_rx_pkg.sv
// Shared PHY definitions: idle/alignment comma and the receiver state encoding.
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: comma-based byte alignment, lock after BC_COUNT
// aligned commas, then MSB-first byte reassembly with a one-cycle valid pulse.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::state_t;
  import serial_paralelo_rx_pkg::SEARCH;
  import serial_paralelo_rx_pkg::ALIGN;
  import serial_paralelo_rx_pkg::ACTIVE;
#(
  parameter int unsigned BC_COUNT = 4,
  parameter logic [7:0]  COMMA    = serial_paralelo_rx_pkg::COMMA
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BC_W   = 4;

  state_t            state, state_n;
  logic [BYTE_W-1:0] sr;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [BC_W-1:0]   bc_cnt, bc_cnt_n;
  logic [BYTE_W-1:0] data_n;
  logic              valid_n;
  logic              active_n;

  logic [BYTE_W-1:0] window_c;
  logic              boundary_c;
  logic              is_comma_c;
  logic              lock_hit_c;

  assign window_c   = {sr[BYTE_W-2:0], data_in};
  assign boundary_c = (bit_cnt == BIT_W'(7));
  assign is_comma_c = (window_c == COMMA);
  assign lock_hit_c = ((bc_cnt + BC_W'(1)) == BC_W'(BC_COUNT));

  // State, shift register, counters and registered outputs
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= window_c;
      bit_cnt   <= bit_cnt_n;
      bc_cnt    <= bc_cnt_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      active    <= active_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt + BIT_W'(1);
    bc_cnt_n  = bc_cnt;
    data_n    = data_out;
    valid_n   = 1'b0;
    active_n  = active;

    unique case (state)
      SEARCH: begin
        bit_cnt_n = bit_cnt;
        if (is_comma_c) begin
          bit_cnt_n = '0;
          bc_cnt_n  = BC_W'(1);
          if (BC_COUNT == 32'd1) begin
            state_n  = ACTIVE;
            active_n = 1'b1;
          end else begin
            state_n = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (boundary_c) begin
          if (is_comma_c) begin
            bc_cnt_n = bc_cnt + BC_W'(1);
            if (lock_hit_c) begin
              state_n  = ACTIVE;
              active_n = 1'b1;
            end
          end else begin
            state_n  = SEARCH;
            bc_cnt_n = '0;
          end
        end
      end
      ACTIVE: begin
        // Alignment is frozen; only byte boundaries carry data
        if (boundary_c && !is_comma_c) begin
          data_n  = window_c;
          valid_n = 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: two instances (BC_COUNT=4 and BC_COUNT=1) on one
// stream, checked every cycle against a cycle/phase model plus literal checkpoints.
module tb_serial_paralelo_rx;

  localparam logic [7:0] K = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_o  [2];
  logic       valid_o [2];
  logic       active_o[2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit started = 1'b0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo_rx #(.BC_COUNT(4)) dut_a (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_o[0]), .valid_out(valid_o[0]), .active(active_o[0])
  );

  serial_paralelo_rx #(.BC_COUNT(1)) dut_b (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_o[1]), .valid_out(valid_o[1]), .active(active_o[1])
  );

  // Model: remembers the cycle at which alignment was found and tests the
  // last 8 bits every multiple of 8 cycles after that anchor.
  logic [7:0] m_win   [2];
  bit         m_align [2];
  bit         m_lock  [2];
  int         m_anchor[2];
  int         m_count [2];
  logic [7:0] m_data  [2];
  bit         m_valid [2];

  always @(posedge clk_32f) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      int  need;
      bit  comma;
      bit  on_byte;
      need = (d == 0) ? 4 : 1;
      if (reset) begin
        m_win[d] = 8'h00; m_align[d] = 0; m_lock[d] = 0; m_anchor[d] = 0;
        m_count[d] = 0; m_data[d] = 8'h00; m_valid[d] = 0;
      end else begin
        m_win[d]   = {m_win[d][6:0], data_in};
        m_valid[d] = 0;
        comma      = (m_win[d] == K);
        on_byte    = (((cyc - m_anchor[d]) % 8) == 0);
        if (m_lock[d]) begin
          if (on_byte && !comma) begin
            m_data[d]  = m_win[d];
            m_valid[d] = 1;
          end
        end else if (m_align[d]) begin
          if (on_byte) begin
            if (comma) begin
              m_count[d] = m_count[d] + 1;
              if (m_count[d] == need) m_lock[d] = 1;
            end else begin
              m_align[d] = 0;
              m_count[d] = 0;
            end
          end
        end else if (comma) begin
          m_align[d]  = 1;
          m_anchor[d] = cyc;
          m_count[d]  = 1;
          if (need == 1) m_lock[d] = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, plus pulse log for dut_a
  logic [7:0] pulse_data[$];
  int         pulse_cyc [$];

  always @(negedge clk_32f) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("model_active[%0d]", d), {7'd0, active_o[d]}, {7'd0, m_lock[d]});
        check($sformatf("model_valid[%0d]", d), {7'd0, valid_o[d]}, {7'd0, m_valid[d]});
        check($sformatf("model_data[%0d]", d), data_o[d], m_data[d]);
      end
      if (valid_o[0] === 1'b1) begin
        pulse_data.push_back(data_o[0]);
        pulse_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int c0;
    logic [7:0] bc_v;
    logic [7:0] b34;
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    started = 1'b1;
    check("reset_active", {7'd0, active_o[0]}, 8'h00);
    check("reset_valid", {7'd0, valid_o[0]}, 8'h00);
    check("reset_data", data_o[0], 8'h00);
    reset = 1'b0;

    // Lock after 4 commas; active rises only at the 32nd bit
    bc_v = K;
    repeat (3) send_byte(K);
    for (int i = 7; i >= 1; i--) send_bit(bc_v[i]);
    check("lock_pre_active", {7'd0, active_o[0]}, 8'h00);
    send_bit(bc_v[0]);
    check("lock_active", {7'd0, active_o[0]}, 8'h01);
    check("bc1_active_early", {7'd0, active_o[1]}, 8'h01);

    // Data, comma, data
    send_byte(8'hA5);
    check("a5_valid", {7'd0, valid_o[0]}, 8'h01);
    check("a5_data", data_o[0], 8'hA5);
    c0 = cyc;
    send_byte(K);
    check("comma_valid", {7'd0, valid_o[0]}, 8'h00);
    check("comma_hold", data_o[0], 8'hA5);
    send_byte(8'h3C);
    check("3c_valid", {7'd0, valid_o[0]}, 8'h01);
    check("3c_data", data_o[0], 8'h3C);
    check("3c_spacing", 8'(cyc - c0), 8'd16);

    // Garbage offset, broken alignment, relock
    pulse_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(K); send_byte(K); send_byte(8'h00);
    repeat (3) send_byte(K);
    check("realign_pre", {7'd0, active_o[0]}, 8'h00);
    send_byte(K);
    check("realign_active", {7'd0, active_o[0]}, 8'h01);

    // Reset in the middle of a data byte
    send_byte(8'h12);
    check("12_data", data_o[0], 8'h12);
    b34 = 8'h34;
    for (int i = 7; i >= 4; i--) send_bit(b34[i]);
    data_in = b34[3];
    pulse_reset();
    check("midrst_active", {7'd0, active_o[0]}, 8'h00);
    check("midrst_data", data_o[0], 8'h00);
    check("midrst_valid", {7'd0, valid_o[0]}, 8'h00);
    for (int i = 2; i >= 0; i--) send_bit(b34[i]);
    repeat (3) send_byte(K);
    check("relock_pre", {7'd0, active_o[0]}, 8'h00);
    check("relock_data", data_o[0], 8'h00);
    send_byte(K);
    check("relock_active", {7'd0, active_o[0]}, 8'h01);

    // Back-to-back stream after 4 idle bytes
    pulse_reset();
    pulse_data.delete();
    pulse_cyc.delete();
    repeat (4) send_byte(K);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    send_byte(K);
    check("b2b_count", 8'(pulse_data.size()), 8'd8);
    for (int i = 0; i < 8 && i < pulse_data.size(); i++) begin
      check($sformatf("b2b_data%0d", i), pulse_data[i], 8'(i + 1));
      if (i > 0) check($sformatf("b2b_gap%0d", i), 8'(pulse_cyc[i] - pulse_cyc[i-1]), 8'd8);
    end

    // Single-comma lock on the BC_COUNT=1 instance
    pulse_reset();
    send_byte(K);
    check("bc1_active", {7'd0, active_o[1]}, 8'h01);
    check("bc1_a_not_active", {7'd0, active_o[0]}, 8'h00);
    send_byte(8'hFF);
    check("bc1_ff_valid", {7'd0, valid_o[1]}, 8'h01);
    check("bc1_ff_data", data_o[1], 8'hFF);
    send_byte(K);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- PHY receive-side deserializer. Sits directly downstream of the parallel-to-serial transmitter and consumes its 1-bit stream on clk_32f.
- Finds byte alignment using the idle comma 8'hBC, which the transmitter sends whenever its valid input is 0.
- Once aligned, rebuilds bytes MSB first and presents non-comma bytes as data with a one-cycle valid pulse.

Parameters:
- BC_COUNT, 4: consecutive aligned commas required before the block declares lock (active); legal range 1-15.
- COMMA, 8'hBC: idle/alignment symbol.

Ports:
- clk_32f  input  1  bit clock; all logic is sampled on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit stream, MSB of each byte first.
- data_out  output  8  last received non-comma byte.
- valid_out  output  1  one-cycle pulse when data_out is loaded with a new byte.
- active  output  1  alignment locked.

Behaviour:
- Window definition: window = {sr[6:0], data_in}. sr is an 8-bit shift register that loads the window on every edge outside reset.
- Reset (reset=1 at an edge):
  - state=SEARCH; sr, bit_cnt (3b) and bc_cnt (4b) all 0.
  - data_out=8'h00, valid_out=0, active=0.
  - Reset wins over every simultaneous event.
  - Reset mid-byte or mid-lock discards partial bytes and drops lock in that same edge.
- SEARCH (bit-by-bit hunt):
  - On each edge, if window==COMMA: bit_cnt<=0 and bc_cnt<=1.
  - Next state is ALIGN, or ACTIVE (with active<=1) if BC_COUNT==1.
  - Otherwise remain in SEARCH.
  - No false match is possible on a continuous COMMA stream; no rotation of 8'hBC equals 8'hBC.
- ALIGN:
  - bit_cnt increments every edge and wraps 7->0.
  - A byte boundary is the edge where bit_cnt==7.
  - At a boundary with window==COMMA: bc_cnt++. If bc_cnt+1==BC_COUNT, go to ACTIVE and set active<=1 in that edge.
  - At a boundary with window!=COMMA: go to SEARCH and set bc_cnt<=0.
  - Non-boundary matches are ignored.
- ACTIVE:
  - Alignment is frozen. bit_cnt keeps wrapping; comma-like patterns straddling byte boundaries are ignored.
  - At a boundary with window!=COMMA: data_out<=window and valid_out<=1 for exactly one cycle.
  - At a boundary with window==COMMA: valid_out<=0 and data_out holds its value.
  - No loss-of-lock detection; ACTIVE persists until reset.
- valid_out is 0 on every non-boundary edge and in SEARCH/ALIGN. data_out is never loaded before lock.
- Latency:
  - The byte's last bit (LSB) is captured at edge k. data_out and valid_out are valid immediately after edge k, i.e. one clk_32f edge after that LSB is presented.
  - active rises at the edge capturing the LSB of the BC_COUNT-th aligned comma.
- Throughput: at most one valid_out pulse per 8 clocks; pulses on back-to-back data bytes are exactly 8 clocks apart.

Decomposition:
- Shared PHY package: COMMA (8'hBC) constant and the state encoding (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2).
- This package is also used by the transmitter for its idle symbol.
- Single module; the FSM, counters and shift register are too tightly coupled to justify a sub-module.

Test Plan:
- Reset, then 4 x 8'hBC MSB first starting at cycle 0 -> active=0 through cycle 30; active=1 after the edge at cycle 31; valid_out stays 0 throughout.
- After lock, send 8'hA5, 8'hBC, 8'h3C -> valid_out pulses with data_out=8'hA5 after the 8'hA5 LSB edge. No pulse at the comma byte, data_out holds 8'hA5. Pulse with 8'h3C 16 clocks after the first pulse.
- 3 garbage bits (1,0,1), then 2 x 8'hBC, then 8'h00, then 4 x 8'hBC -> alignment found on the first comma (bit offset 3). The 8'h00 returns the FSM to SEARCH. Lock reached at the end of the 4th subsequent comma; no valid_out before lock.
- Locked stream 8'h12, 8'h34 with reset=1 asserted for 1 cycle mid-8'h34 -> next edge: active=0, data_out=8'h00, valid_out=0. 8'h34 is never output, and relock needs 4 new commas.
- Back-to-back loopback from the transmitter (data 8'h01..8'h08 with valid=1 after 4 idle bytes, shared clk_32f) -> 8 valid_out pulses 8 clocks apart carrying 8'h01..8'h08 in order.
- BC_COUNT=1 build: a single 8'hBC -> active=1 at its LSB edge; the next byte 8'hFF is output with valid_out=1.
